// File: rtl/cnn_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_fifo_pkg;

  // Default geometry and flag thresholds.
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = DEF_DEPTH - 2;
  localparam int DEF_AE_THRESH = 2;

  // Address bits needed to index 'depth' entries (ceil(log2)), at least 1.
  function automatic int ptr_w(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read data follows rd_addr with no clock.
// Backpressure: none; the caller only asserts wr_en for accepted writes.
module fifo_mem
  import cnn_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are intentionally not reset; validity is tracked by the pointers.
  logic [WIDTH-1:0] mem [DEPTH];

  // Store the accepted write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sfifo.sv
// Parameterised single-clock FIFO with occupancy flags and sticky error flags.
// Latency: FWFT=0 data one edge after an accepted read; FWFT=1 head word shown combinationally.
// Backpressure: writes refused while full, reads refused while empty; refusals set sticky flags.
module param_sfifo
  import cnn_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Reject geometries the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sfifo: DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sfifo: WIDTH must be >= 1");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] mem_rd_data;
  logic             wr_acc;
  logic             rd_acc;

  // Flags are pure decodes of the registered occupancy.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_THRESH);
  assign almost_empty = (int'(count_q) <= AE_THRESH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance only looks at the current flags, so a read never frees space
  // for a write in the same cycle. Requests during reset are ignored.
  assign wr_acc = wr_en & ~full  & ~rest;
  assign rd_acc = rd_en & ~empty & ~rest;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Advance pointers and occupancy on accepted transfers; wrap is implicit
  // because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags record any refused request until the next reset.
  always_ff @(posedge clk) begin
    if (rest) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is always on the bus; a pop simply moves to the next entry.
    assign rd_data  = mem_rd_data;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Capture the popped word; rd_valid pulses for the cycle after the pop
    // while rd_data keeps its last value otherwise.
    always_ff @(posedge clk) begin
      if (rest) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem_rd_data;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_param_sfifo.sv
// Bench for param_sfifo: registered-read and FWFT instances driven in lockstep.
// Latency: expectations follow a queue model updated at each clock edge.
// Backpressure: full/empty refusals and sticky flags come from the model.
module tb_param_sfifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk;
  logic             rest;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;

  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             rd_valid0, rd_valid1;
  logic             full0, full1, empty0, empty1;
  logic             af0, af1, ae0, ae1;
  logic [3:0]       count0, count1;
  logic             ovf0, ovf1, udf0, udf1;

  param_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut0 (
    .clk(clk), .rest(rest), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  param_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut1 (
    .clk(clk), .rest(rest), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue of words.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp0[$];
  bit               m_ovf, m_udf, m_rv0;
  logic [WIDTH-1:0] m_last0;
  bit               mon_on;
  int               n_cmp, n_err;
  int               max_cnt;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock of stimulus; model outcome decided from pre-edge state and
  // committed right after the edge so the negedge monitor sees post-edge state.
  task automatic cycle(input bit we, input logic [WIDTH-1:0] wd, input bit re, input bit rs);
    bit f, e, wacc, racc;
    rest    = rs;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    f    = (m_q.size() == DEPTH);
    e    = (m_q.size() == 0);
    wacc = we && !f && !rs;
    racc = re && !e && !rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_ovf   = 0;
      m_udf   = 0;
      m_rv0   = 0;
      m_last0 = '0;
    end else begin
      if (we && f) m_ovf = 1;
      if (re && e) m_udf = 1;
      m_rv0 = racc;
      if (racc) begin
        m_last0 = m_q[0];
        exp0.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (wacc) m_q.push_back(wd);
    end
    if (m_q.size() > max_cnt) max_cnt = m_q.size();
    #1;
  endtask

  // Monitor: compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      int sz;
      sz = m_q.size();
      chk("count0", int'(count0), sz);
      chk("count1", int'(count1), sz);
      chk("full0",  int'(full0),  int'(sz == DEPTH));
      chk("empty0", int'(empty0), int'(sz == 0));
      chk("af0",    int'(af0),    int'(sz >= AF));
      chk("ae0",    int'(ae0),    int'(sz <= AE));
      chk("full1",  int'(full1),  int'(sz == DEPTH));
      chk("empty1", int'(empty1), int'(sz == 0));
      chk("af1",    int'(af1),    int'(sz >= AF));
      chk("ae1",    int'(ae1),    int'(sz <= AE));
      chk("ovf0",   int'(ovf0),   int'(m_ovf));
      chk("udf0",   int'(udf0),   int'(m_udf));
      chk("ovf1",   int'(ovf1),   int'(m_ovf));
      chk("udf1",   int'(udf1),   int'(m_udf));
      chk("rd_valid0", int'(rd_valid0), int'(m_rv0));
      if (rd_valid0) begin
        if (exp0.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_data0: got %0d with no word expected", rd_data0);
        end else begin
          chk("rd_data0", int'(rd_data0), int'(exp0.pop_front()));
        end
      end else begin
        chk("rd_hold0", int'(rd_data0), int'(m_last0));
      end
      chk("rd_valid1", int'(rd_valid1), int'(sz != 0));
      if (sz != 0) chk("rd_data1", int'(rd_data1), int'(m_q[0]));
    end
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    mon_on  = 0;
    max_cnt = 0;
    m_ovf   = 0;
    m_udf   = 0;
    m_rv0   = 0;
    m_last0 = '0;
    rest = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset state
    cycle(0, 8'h00, 0, 1);
    mon_on = 1;
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0);

    // Fill 0x01..0x08, then one write too many
    for (int i = 1; i <= 8; i++) cycle(1, WIDTH'(i), 0, 0);
    cycle(1, 8'hEE, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Drain 8 words, then one read too many
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Alternating write/read pairs across pointer wrap
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, WIDTH'(8'h10 + i), 0, 0);
      cycle(0, 8'h00, 1, 0);
    end
    cycle(0, 8'h00, 0, 0);
    chk("wrap_max_count", max_cnt, 1);

    // Simultaneous at count 4, then at full
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(8'h40 + i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, WIDTH'(8'h50 + i), 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(8'h60 + i), 0, 0);
    cycle(1, 8'h77, 1, 0);
    cycle(0, 8'h00, 0, 0);
    chk("simul_full_count", int'(count0), 7);

    // Reset at count 5 with requests asserted
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h99, 1, 1);
    cycle(0, 8'h00, 0, 0);

    // FWFT visibility: lone write, idle, pop
    cycle(1, 8'hA5, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("fwft_a5", int'(rd_data1), 8'hA5);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Randomized traffic with changing write/read bias and rare resets
    for (int i = 0; i < 3000; i++) begin
      int ph, pw, pr;
      ph = (i / 250) % 3;
      pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 55;
      pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 55;
      cycle($urandom_range(0, 99) < pw, WIDTH'($urandom), $urandom_range(0, 99) < pr,
            $urandom_range(0, 299) == 0);
    end
    cycle(0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk("exp0_drained", exp0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
